pmu_reg_arbiter: RTL and testbench

PMU_REG_ARBITER -- requirements
Module: pmu_reg_arbiter

---
 rtl/pmu_reg_arbiter.sv | 140 ++++++++++++++
 tb/tb_pmu_reg_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_reg_arbiter.sv
// Round-robin arbiter between the AHB slave path and the local sequencer for PMU register bank access.
// One access per two cycles; a requester holding lock_i keeps the bank until it lets go.
module pmu_reg_arbiter #(
  parameter int REG_WIDTH = 32,
  parameter int N_REGS    = 26,
  parameter int N_REQ     = 2,
  localparam int IDX_W    = $clog2(N_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           we_i,
  input  logic [N_REQ-1:0]           lock_i,
  input  logic [N_REQ*IDX_W-1:0]     addr_i,
  input  logic [N_REQ*REG_WIDTH-1:0] wdata_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           rvalid_o,
  output logic [N_REQ-1:0]           err_o,
  output logic [REG_WIDTH-1:0]       rdata_o,
  output logic                       bank_we_o,
  output logic [IDX_W-1:0]           bank_idx_o,
  output logic [REG_WIDTH-1:0]       bank_wdata_o,
  input  logic [REG_WIDTH-1:0]       bank_rdata_i,
  output logic [1:0]                 dbg_state_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Handshake: a requester raises req_i with we/addr/wdata stable and holds them until
  // its one-cycle gnt_o; from the following cycle it may drop req_i or present a new access.
  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     win_q;
  logic [PTR_W-1:0]     pick;
  logic                 pick_vld;
  logic [PTR_W-1:0]     src;
  logic                 load;
  int                   rr_c;
  logic                 lat_we_q;
  logic [IDX_W-1:0]     lat_idx_q;
  logic [REG_WIDTH-1:0] lat_wdata_q;
  logic [N_REQ-1:0]     rvalid_q;
  logic [REG_WIDTH-1:0] rdata_q;
  logic [N_REQ-1:0]     win_oh;
  logic                 in_range;
  logic                 in_access;

  assign in_access = (state_q == ACCESS);
  assign in_range  = ({1'b0, lat_idx_q} < (IDX_W+1)'(N_REGS));

  // Round-robin search starting at ptr_q
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_c     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_c = int'(ptr_q) + i;
      if (rr_c >= N_REQ) rr_c = rr_c - N_REQ;
      if (!pick_vld && req_i[rr_c]) begin
        pick_vld = 1'b1;
        pick     = PTR_W'(rr_c);
      end
    end
  end

  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    src     = win_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ACCESS;
          load    = 1'b1;
          src     = pick;
        end
      end
      ACCESS: begin
        state_d = (lock_i[win_q] && req_i[win_q]) ? LOCKED : IDLE;
      end
      LOCKED: begin
        if (!lock_i[win_q]) begin
          state_d = IDLE;
        end else if (req_i[win_q]) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        win_q       <= src;
        lat_we_q    <= we_i[src];
        lat_idx_q   <= addr_i[src*IDX_W +: IDX_W];
        lat_wdata_q <= wdata_i[src*REG_WIDTH +: REG_WIDTH];
      end
      if (in_access) begin
        ptr_q <= (win_q == PTR_W'(N_REQ-1)) ? '0 : win_q + PTR_W'(1);
      end
      rvalid_q <= '0;
      if (in_access && !lat_we_q && in_range) begin
        rvalid_q <= win_oh;
        rdata_q  <= bank_rdata_i;
      end
    end
  end

  assign gnt_o        = in_access ? win_oh : '0;
  assign err_o        = (in_access && !in_range) ? win_oh : '0;
  assign bank_we_o    = in_access && lat_we_q && in_range;
  assign bank_idx_o   = lat_idx_q;
  assign bank_wdata_o = lat_wdata_q;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pmu_reg_arbiter.sv
// Directed bench for pmu_reg_arbiter: vector table for single accesses plus
// hand-written sequences for contention, lock and reset-during-access.
module tb_pmu_reg_arbiter;

  localparam int W  = 32;
  localparam int NR = 26;
  localparam int IW = 5;

  logic          clk;
  logic          rstn;
  logic [1:0]    req, we, lock;
  logic [2*IW-1:0] addr;
  logic [2*W-1:0]  wdata;
  logic [1:0]    gnt_o, rvalid_o, err_o;
  logic [W-1:0]  rdata_o;
  logic          bank_we_o;
  logic [IW-1:0] bank_idx_o;
  logic [W-1:0]  bank_wdata_o;
  logic [W-1:0]  bank_rdata_i;
  logic [1:0]    dbg_state_o;

  int n_cmp;
  int n_bad;

  pmu_reg_arbiter #(.REG_WIDTH(W), .N_REGS(NR), .N_REQ(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .err_o(err_o), .rdata_o(rdata_o), .bank_we_o(bank_we_o),
    .bank_idx_o(bank_idx_o), .bank_wdata_o(bank_wdata_o),
    .bank_rdata_i(bank_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register bank model
  logic [W-1:0] mem [32];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem[5] <= 32'h0000_1234;
    end else if (bank_we_o) begin
      mem[bank_idx_o] <= bank_wdata_o;
    end
  end
  assign bank_rdata_i = (int'(bank_idx_o) < NR) ? mem[bank_idx_o] : '0;

  typedef struct {
    int          r;
    logic        we;
    logic [IW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [1:0]  exp_gnt;
    logic        exp_we;
    logic [1:0]  exp_err;
    logic [1:0]  exp_rvalid;
    logic [W-1:0]  exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic w, input logic [IW-1:0] a, input logic [W-1:0] d);
    req[r] = 1'b1;
    we[r]  = w;
    addr[r*IW +: IW] = a;
    wdata[r*W +: W]  = d;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat;
    bit got;
    string tag;
    tag = $sformatf("vec%0d", n);
    got = 0;
    lat = 0;
    set_req(v.r, v.we, v.addr, v.wdata);
    for (int k = 0; k < 6; k++) begin
      tick();
      lat++;
      if (gnt_o !== 2'b00) begin
        got = 1;
        break;
      end
    end
    check({tag, "_gnt_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd1);
    check({tag, "_gnt"}, 32'(gnt_o), 32'(v.exp_gnt));
    check({tag, "_bank_we"}, 32'(bank_we_o), 32'(v.exp_we));
    check({tag, "_err"}, 32'(err_o), 32'(v.exp_err));
    check({tag, "_bank_idx"}, 32'(bank_idx_o), 32'(v.addr));
    if (v.exp_we) check({tag, "_bank_wdata"}, bank_wdata_o, v.wdata);
    tick();
    req[v.r] = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid_o), 32'(v.exp_rvalid));
    check({tag, "_rdata"}, rdata_o, v.exp_rdata);
    check({tag, "_we_after"}, 32'(bank_we_o), 32'd0);
    tick();
    check({tag, "_rvalid_drop"}, 32'(rvalid_o), 32'd0);
    check({tag, "_rdata_hold"}, rdata_o, v.exp_rdata);
    check({tag, "_gnt_idle"}, 32'(gnt_o), 32'd0);
  endtask

  logic [1:0] cexp [8];
  int  n01;
  bit  got10, both, drop_pend;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;

    //           r  we addr  wdata          gnt   we    err   rvalid rdata
    vecs[0] = '{0, 1'b1, 5'd3,  32'hDEADBEEF, 2'b01, 1'b1, 2'b00, 2'b00, 32'h0};
    vecs[1] = '{1, 1'b0, 5'd5,  32'h0,        2'b10, 1'b0, 2'b00, 2'b10, 32'h0000_1234};
    vecs[2] = '{1, 1'b0, 5'd3,  32'h0,        2'b10, 1'b0, 2'b00, 2'b10, 32'hDEADBEEF};
    vecs[3] = '{0, 1'b1, 5'd25, 32'hA5A50001, 2'b01, 1'b1, 2'b00, 2'b00, 32'hDEADBEEF};
    vecs[4] = '{0, 1'b0, 5'd25, 32'h0,        2'b01, 1'b0, 2'b00, 2'b01, 32'hA5A50001};
    vecs[5] = '{0, 1'b1, 5'd26, 32'hFFFFFFFF, 2'b01, 1'b0, 2'b01, 2'b00, 32'hA5A50001};
    vecs[6] = '{1, 1'b0, 5'd31, 32'h0,        2'b10, 1'b0, 2'b10, 2'b00, 32'hA5A50001};
    vecs[7] = '{1, 1'b1, 5'd0,  32'h0BADF00D, 2'b10, 1'b1, 2'b00, 2'b00, 32'hA5A50001};
    vecs[8] = '{0, 1'b0, 5'd0,  32'h0,        2'b01, 1'b0, 2'b00, 2'b01, 32'h0BADF00D};
    vecs[9] = '{1, 1'b0, 5'd26, 32'h0,        2'b10, 1'b0, 2'b10, 2'b00, 32'h0BADF00D};

    cexp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    // reset state, before and after clock edges
    #2;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_bank_we", 32'(bank_we_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);
    tick();
    tick();
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_bank_idx", 32'(bank_idx_o), 32'd0);
    check("rst_bank_wdata", bank_wdata_o, 32'd0);
    rstn = 1'b1;
    tick();

    // contention: both requesters hold req continuously
    set_req(0, 1'b1, 5'd10, 32'h1010_1010);
    set_req(1, 1'b1, 5'd11, 32'h1111_1111);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("cont_gnt%0d", i), 32'(gnt_o), 32'(cexp[i]));
    end
    req = '0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // lock: requester 0 keeps the bank for three accesses while requester 1 waits
    n01 = 0;
    got10 = 0;
    both = 0;
    drop_pend = 0;
    lock[0] = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'h0000_0011);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (drop_pend) begin
        req[0]  = 1'b0;
        lock[0] = 1'b0;
        drop_pend = 0;
      end
      if (gnt_o == 2'b11) both = 1;
      if (gnt_o == 2'b01) begin
        n01++;
        if (n01 == 1) set_req(1, 1'b1, 5'd2, 32'h0000_0022);
        if (n01 == 3) drop_pend = 1;
      end
      if (gnt_o == 2'b10) begin
        got10 = 1;
        break;
      end
    end
    check("lock_n_gnt0", 32'(n01), 32'd3);
    check("lock_gnt1_seen", 32'(got10), 32'd1);
    check("lock_no_double", 32'(both), 32'd0);
    tick();
    req = '0;
    tick();
    tick();

    // reset in the ACCESS cycle of a write, with ptr pointing at requester 1
    run_vec('{0, 1'b1, 5'd4, 32'h0000_0044, 2'b01, 1'b1, 2'b00, 2'b00, 32'h0BADF00D}, 10);
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    tick();
    check("rstmid_pre_gnt", 32'(gnt_o), 32'b01);
    check("rstmid_pre_we", 32'(bank_we_o), 32'd1);
    rstn = 1'b0;
    #1;
    check("rstmid_bank_we", 32'(bank_we_o), 32'd0);
    check("rstmid_gnt", 32'(gnt_o), 32'd0);
    check("rstmid_rvalid", 32'(rvalid_o), 32'd0);
    check("rstmid_err", 32'(err_o), 32'd0);
    check("rstmid_rdata", rdata_o, 32'd0);
    check("rstmid_bank_idx", 32'(bank_idx_o), 32'd0);
    check("rstmid_bank_wdata", bank_wdata_o, 32'd0);
    req = '0;
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rstmid_quiet_gnt%0d", k), 32'(gnt_o), 32'd0);
      check($sformatf("rstmid_quiet_rv%0d", k), 32'(rvalid_o), 32'd0);
    end
    set_req(0, 1'b1, 5'd8, 32'h0000_0088);
    set_req(1, 1'b1, 5'd9, 32'h0000_0099);
    tick();
    check("rstmid_first_gnt", 32'(gnt_o), 32'b01);
    req = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
